fixed_mult_pipe: RTL and testbench
==================================

// Module: fixed_mult_pipe
// PURPOSE
//  Pipelined signed fixed-point multiplier: the registered, handshaked successor to the combinational Q24.8 multiply.
//  Sits in the gradient-descent datapath: weight*gradient and learning-rate*gradient products.
//  Generalised over operand width, fraction bits and output width; selectable rounding; optional saturation.
//  Keeps a running saturation count for the training controller.
// PARAMETERS
//  DATA_W     32  operand width, signed, two's complement
//  FRAC_W     8   fraction bits of both operands and of the result (Q(DATA_W-FRAC_W).FRAC_W)
//  OUT_W      32  result width; legal range FRAC_W+2 .. 2*DATA_W-FRAC_W
//  ROUND_MODE 0   0 = truncate (arithmetic shift, floor); 1 = round half up (add 2^(FRAC_W-1) before shift)
//  SATURATE   1   1 = clamp to OUT_W signed range; 0 = wrap (keep low OUT_W bits)
//  CNT_W      16  width of sat_count
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        a_in/b_in valid
//  in_ready   out  1        block accepts an operand pair this cycle
//  a_in       in   DATA_W   operand A, signed fixed-point
//  b_in       in   DATA_W   operand B, signed fixed-point
//  out_valid  out  1        p_out/ovf valid
//  out_ready  in   1        downstream accepts result
//  p_out      out  OUT_W    product, same Q format fraction as inputs
//  ovf        out  1        this result was saturated (SATURATE=1) or wrapped (SATURATE=0)
//  clr_stats  in   1        synchronous clear of sat_count
//  sat_count  out  CNT_W    number of delivered results with ovf=1; sticks at all-ones
// BEHAVIOUR
//  - Reset (async, rst_n=0): all stage valids 0, out_valid 0, p_out 0, ovf 0, sat_count 0. Pairs in flight are discarded.
//  - Three register stages: S1 capture a,b; S2 full 2*DATA_W signed product; S3 round, shift by FRAC_W, range check.
//  - advance = !(out_valid && !out_ready). All stages shift together when advance=1; all hold when 0.
//  - in_ready = advance (combinational). Transfer at input when in_valid && in_ready; at output when out_valid && out_ready.
//  - Latency: pair accepted in cycle N appears on p_out with out_valid=1 in cycle N+3 when never stalled.
//  - Throughput 1 pair/cycle. Bubbles are not collapsed; order is strictly preserved.
//  - While stalled, p_out, ovf, out_valid held stable; no pair is lost or duplicated.
//  - Rounding: ROUND_MODE=1 adds 2^(FRAC_W-1) to full product before >>> FRAC_W (ties go toward +inf, e.g. -0.5 LSB -> 0).
//  - Range check on shifted value (2*DATA_W-FRAC_W+1 bits, incl. rounding carry) against [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//    SATURATE=1: out of range -> clamp to min/max, ovf=1. SATURATE=0: low OUT_W bits, ovf=1 on wrap.
//  - sat_count increments on each output transfer with ovf=1; holds at 2^CNT_W-1.
//  - clr_stats=1 zeroes sat_count next edge; if coincident with an ovf transfer, the clear wins (result 0).
//  - Bubble outputs: p_out/ovf are don't-care when out_valid=0 but must not be X after reset (S3 data regs reset to 0).
// STRUCTURE
//  - Shared package fixed_pkg: ROUND_TRUNC=0, ROUND_HALF_UP=1 constants; default Q24.8 widths (Q_DATA_W, Q_FRAC_W).
//  - One combinational sub-module fixed_round_sat (params IN_W, FRAC_W, OUT_W, ROUND_MODE, SATURATE):
//    full product in -> p_out, ovf out. Instantiated in S3; reusable by other fixed-point blocks.
//  - Top holds pipeline valid/data registers, advance logic and sat_count.
// TESTING (defaults Q24.8 unless stated)
//  1. 1.5*2.0: a=0x180, b=0x200, out_ready=1 -> p_out=0x300, ovf=0, out_valid exactly 3 cycles after accept.
//  2. Sign: -1.5*2.0: a=0xFFFFFE80, b=0x200 -> p_out=0xFFFFFD00; -1*-1 (0xFFFFFF00 twice) -> 0x100.
//  3. Rounding: a=0x001, b=0x080 -> ROUND_MODE=0 gives 0x0, ROUND_MODE=1 gives 0x1; a=0xFFFFFFFF,b=0x080 -> 0xFFFFFFFF / 0x0.
//  4. Saturation: a=b=0x7FFFFFFF -> p_out=0x7FFFFFFF, ovf=1; a=0x7FFFFFFF,b=0x80000000 -> 0x80000000, ovf=1; sat_count=2.
//  5. Backpressure: stream 20 random pairs with in_valid=1, out_ready low for cycles 5..9 -> in_ready=0 during stall,
//     p_out stable, all 20 results match reference model in order, none duplicated.
//  6. Reset mid-stream: assert rst_n=0 with 3 pairs in flight -> out_valid=0 and sat_count=0 immediately; no stale result after release.

Source files
------------

// File: rtl/fixed_pkg.sv
// Shared fixed-point constants: rounding mode selectors and default Q24.8 widths.
package fixed_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  localparam int Q_DATA_W = 32;
  localparam int Q_FRAC_W = 8;

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational post-processing of a full-width signed product: optional rounding,
// arithmetic shift by FRAC_W, then saturate or wrap into OUT_W bits with an overflow flag.
module fixed_round_sat
  import fixed_pkg::*;
#(
  parameter int IN_W       = 2 * Q_DATA_W,
  parameter int FRAC_W     = Q_FRAC_W,
  parameter int OUT_W      = Q_DATA_W,
  parameter int ROUND_MODE = ROUND_TRUNC,
  parameter int SATURATE   = 1
) (
  input  logic signed [IN_W-1:0]  prod,
  output logic        [OUT_W-1:0] p_out,
  output logic                    ovf
);

  // One extra bit keeps the rounding carry from overflowing the sum.
  localparam int SH_W    = IN_W - FRAC_W + 1;
  localparam int RND_POS = (FRAC_W > 0) ? FRAC_W - 1 : 0;
  localparam logic [IN_W:0] RND =
    (ROUND_MODE == ROUND_HALF_UP && FRAC_W > 0) ? ((IN_W + 1)'(1) << RND_POS) : '0;

  logic signed [IN_W:0]        ext;
  logic signed [IN_W:0]        rounded;
  logic        [SH_W-1:0]      shifted;
  logic        [SH_W-OUT_W:0]  upper;
  logic                        in_range;

  // Value fits when every bit above the output sign bit matches it.
  always_comb begin
    ext      = {prod[IN_W-1], prod};
    rounded  = ext + $signed(RND);
    shifted  = SH_W'(rounded >>> FRAC_W);
    upper    = shifted[SH_W-1:OUT_W-1];
    in_range = (&upper) || !(|upper);
    p_out    = shifted[OUT_W-1:0];
    ovf      = !in_range;
    if (SATURATE != 0 && !in_range) begin
      p_out = shifted[SH_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fixed_mult_pipe.sv
// Three-stage handshaked signed fixed-point multiplier with a sticky count of
// delivered results that overflowed.
module fixed_mult_pipe
  import fixed_pkg::*;
#(
  parameter int DATA_W     = Q_DATA_W,
  parameter int FRAC_W     = Q_FRAC_W,
  parameter int OUT_W      = 32,
  parameter int ROUND_MODE = ROUND_TRUNC,
  parameter int SATURATE   = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  p_out,
  output logic              ovf,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  sat_count
);

  logic                       advance;
  logic                       v1, v2;
  logic        [DATA_W-1:0]   a_q, b_q;
  logic        [2*DATA_W-1:0] prod_full;
  logic signed [2*DATA_W-1:0] prod_q;
  logic        [OUT_W-1:0]    p_next;
  logic                       ovf_next;

  // The whole pipe freezes only when a finished result is refused downstream.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // Sign-extend both operands so the low 2*DATA_W bits are the signed product.
  assign prod_full = {{DATA_W{a_q[DATA_W-1]}}, a_q} * {{DATA_W{b_q[DATA_W-1]}}, b_q};

  fixed_round_sat #(
    .IN_W      (2 * DATA_W),
    .FRAC_W    (FRAC_W),
    .OUT_W     (OUT_W),
    .ROUND_MODE(ROUND_MODE),
    .SATURATE  (SATURATE)
  ) u_round_sat (
    .prod (prod_q),
    .p_out(p_next),
    .ovf  (ovf_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      prod_q    <= '0;
      p_out     <= '0;
      ovf       <= 1'b0;
    end else if (advance) begin
      v1        <= in_valid;
      a_q       <= a_in;
      b_q       <= b_in;
      v2        <= v1;
      prod_q    <= $signed(prod_full);
      out_valid <= v2;
      p_out     <= p_next;
      ovf       <= ovf_next;
    end
  end

  // Clear takes priority over a coincident overflow delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (clr_stats) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && ovf && (sat_count != {CNT_W{1'b1}})) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fixed_mult_pipe.sv
// Directed and scoreboarded checks of fixed_mult_pipe: default truncate/saturate build
// alongside a round-half-up/wrap build with a 2-bit saturation counter.
module tb_fixed_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        clr_stats = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;

  logic        in_ready, out_valid, ovf;
  logic [31:0] p_out;
  logic [15:0] sat_count;
  logic        r_in_ready, r_out_valid, r_ovf;
  logic [31:0] r_p_out;
  logic [1:0]  r_sat_count;

  int checks = 0;
  int failures = 0;
  int exp_cnt_m = 0;
  int exp_cnt_r = 0;

  always #5 clk = ~clk;

  fixed_mult_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .p_out(p_out), .ovf(ovf), .clr_stats(clr_stats), .sat_count(sat_count)
  );

  fixed_mult_pipe #(.ROUND_MODE(1), .SATURATE(0), .CNT_W(2)) dut_rnd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(r_out_valid), .out_ready(out_ready),
    .p_out(r_p_out), .ovf(r_ovf), .clr_stats(clr_stats), .sat_count(r_sat_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: 64-bit integer product, optional +0.5 LSB, floor shift, range check.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input bit rnd, input bit sat);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    if (rnd) p = p + 128;
    p = p >>> 8;
    if (p > 64'sd2147483647)
      return sat ? {1'b1, 32'h7FFFFFFF} : {1'b1, p[31:0]};
    if (p < -64'sd2147483648)
      return sat ? {1'b1, 32'h80000000} : {1'b1, p[31:0]};
    return {1'b0, p[31:0]};
  endfunction

  task automatic bumpCounts(input logic eo, input logic eor);
    if (eo) exp_cnt_m++;
    if (eor && exp_cnt_r != 3) exp_cnt_r++;
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ep, input logic eo,
                               input logic [31:0] epr, input logic eor);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    #1 checkOutput({tag, ".in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, ".latency"}, lat, 3);
    checkOutput({tag, ".p"}, p_out, ep);
    checkOutput({tag, ".ovf"}, ovf, eo);
    checkOutput({tag, ".r_valid"}, r_out_valid, 1);
    checkOutput({tag, ".r_p"}, r_p_out, epr);
    checkOutput({tag, ".r_ovf"}, r_ovf, eor);
    bumpCounts(eo, eor);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] va[20], vb[20];
    logic [32:0] qm[$], qr[$];
    logic [32:0] em, er;
    logic [31:0] held_p, held_r;
    bit held;
    int sent, recv, cyc, wait_cyc, tmp;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst.out_valid", out_valid, 0);
    checkOutput("rst.p_out", p_out, 0);
    checkOutput("rst.ovf", ovf, 0);
    checkOutput("rst.sat_count", sat_count, 0);
    checkOutput("rst.in_ready", in_ready, 1);

    applyStimulus("mul_1p5x2", 32'h180, 32'h200, 32'h300, 0, 32'h300, 0);
    applyStimulus("neg_1p5x2", 32'hFFFFFE80, 32'h200, 32'hFFFFFD00, 0, 32'hFFFFFD00, 0);
    applyStimulus("neg1xneg1", 32'hFFFFFF00, 32'hFFFFFF00, 32'h100, 0, 32'h100, 0);
    applyStimulus("rnd_pos", 32'h001, 32'h080, 32'h0, 0, 32'h1, 0);
    applyStimulus("rnd_neg", 32'hFFFFFFFF, 32'h080, 32'hFFFFFFFF, 0, 32'h0, 0);
    applyStimulus("sat_max", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1, 32'hFF000000, 1);
    applyStimulus("sat_min", 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 1, 32'h00800000, 1);
    @(negedge clk);
    checkOutput("sat.count2", sat_count, 2);
    checkOutput("sat.r_count2", r_sat_count, 2);
    applyStimulus("sat_max2", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1, 32'hFF000000, 1);
    applyStimulus("sat_min2", 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 1, 32'h00800000, 1);
    @(negedge clk);
    checkOutput("sat.count4", sat_count, exp_cnt_m);
    checkOutput("sat.r_sticky", r_sat_count, 3);

    // Clear coincident with an overflowing delivery.
    in_valid = 1'b1;
    a_in = 32'h7FFFFFFF;
    b_in = 32'h7FFFFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    wait_cyc = 0;
    while (!out_valid && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    checkOutput("clr.valid", out_valid, 1);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    checkOutput("clr.count", sat_count, 0);
    checkOutput("clr.r_count", r_sat_count, 0);
    exp_cnt_m = 0;
    exp_cnt_r = 0;

    // Backpressure stream with a scoreboard.
    for (int i = 0; i < 20; i++) begin
      tmp = $urandom;
      va[i] = 32'(tmp >>> $urandom_range(0, 24));
      tmp = $urandom;
      vb[i] = 32'(tmp >>> $urandom_range(0, 24));
    end
    va[0] = 32'h7FFFFFFF;
    vb[0] = 32'h7FFFFFFF;
    sent = 0;
    recv = 0;
    cyc = 0;
    held = 0;
    while (recv < 20 && cyc < 200) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc <= 9);
      if (sent < 20) begin
        in_valid = 1'b1;
        a_in = va[sent];
        b_in = vb[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready && out_valid) begin
        checkOutput("bp.in_ready", in_ready, 0);
        checkOutput("bp.r_in_ready", r_in_ready, 0);
        if (held) begin
          checkOutput("bp.hold_p", p_out, held_p);
          checkOutput("bp.hold_r", r_p_out, held_r);
        end
        held = 1;
        held_p = p_out;
        held_r = r_p_out;
      end else begin
        held = 0;
      end
      if (in_valid && in_ready) begin
        qm.push_back(model(va[sent], vb[sent], 0, 1));
        qr.push_back(model(va[sent], vb[sent], 1, 0));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (qm.size() == 0) begin
          checkOutput("bp.unexpected", 1, 0);
        end else begin
          em = qm.pop_front();
          er = qr.pop_front();
          checkOutput("bp.result", {ovf, p_out}, em);
          checkOutput("bp.r_result", {r_out_valid, r_ovf, r_p_out}, {1'b1, er});
          bumpCounts(em[32], er[32]);
        end
        recv++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp.received", recv, 20);
    repeat (5) @(negedge clk);
    checkOutput("bp.no_dup", out_valid, 0);
    checkOutput("bp.count", sat_count, exp_cnt_m);
    checkOutput("bp.r_count", r_sat_count, exp_cnt_r);

    // Reset with three pairs in flight after one overflow delivery.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a_in = 32'h7FFFFFFF;
      b_in = 32'h7FFFFFFF;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("mid.count_pre", sat_count, exp_cnt_m + 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid.out_valid", out_valid, 0);
    checkOutput("mid.sat_count", sat_count, 0);
    checkOutput("mid.r_out_valid", r_out_valid, 0);
    checkOutput("mid.r_sat_count", r_sat_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("mid.no_stale", {out_valid, r_out_valid}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
